// File: rtl/conbus_pkg.sv
// Shared constants and helpers for the conbus round-robin arbiter.
package conbus_pkg;

    localparam int unsigned CONBUS_MAX_MASTERS = 8;
    localparam int unsigned CONBUS_RESET_GNT   = 0;

    // Index width for n masters; a 2-master bus still needs one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conbus_rr_pick.sv
// Combinational rotating-priority search: first requester after cur_i,
// wrapping modulo N_MASTERS, never returning cur_i itself.
module conbus_rr_pick
    import conbus_pkg::*;
#(
    parameter  int unsigned N_MASTERS = 4,
    localparam int unsigned IW        = idx_w(N_MASTERS)
) (
    input  logic [N_MASTERS-1:0] req_i,
    input  logic [IW-1:0]        cur_i,
    output logic [IW-1:0]        nxt_o,
    output logic                 found_o
);

    always_comb begin
        logic [31:0] pos;
        pos     = '0;
        nxt_o   = cur_i;
        found_o = 1'b0;
        for (int unsigned i = 1; i < N_MASTERS; i++) begin
            pos = (32'(cur_i) + i) % N_MASTERS;
            if (!found_o && req_i[pos[IW-1:0]]) begin
                found_o = 1'b1;
                nxt_o   = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/conbus_rr_arb.sv
// Round-robin bus arbiter with parked, sticky grant.
// Optional tenure watchdog compiled in with `define CONBUS_ARB_TIMEOUT_EN.
module conbus_rr_arb
    import conbus_pkg::*;
#(
    parameter  int unsigned N_MASTERS = 4,
    parameter  int unsigned MAX_HOLD  = 64,
    localparam int unsigned IW        = idx_w(N_MASTERS)
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [N_MASTERS-1:0] req,
    output logic [N_MASTERS-1:0] gnt,
    output logic [IW-1:0]        gnt_idx,
    output logic                 gnt_chg,
    output logic                 hold_expired
);

    if (N_MASTERS < 2 || N_MASTERS > CONBUS_MAX_MASTERS ||
        MAX_HOLD < 2 || MAX_HOLD > 1024) begin : g_param_check
        $error("conbus_rr_arb: parameter out of legal range");
    end

    logic [IW-1:0] cur_q, cur_d;
    logic          chg_q, chg_d;
    logic [IW-1:0] pick_idx;
    logic          pick_found;
    logic          cur_valid;
    logic          req_cur;
    logic          expire;

    conbus_rr_pick #(
        .N_MASTERS (N_MASTERS)
    ) u_pick (
        .req_i   (req),
        .cur_i   (cur_q),
        .nxt_o   (pick_idx),
        .found_o (pick_found)
    );

    assign cur_valid = (32'(cur_q) < N_MASTERS);
    assign req_cur   = cur_valid ? req[cur_q] : 1'b0;

`ifdef CONBUS_ARB_TIMEOUT_EN
    localparam int unsigned CW        = (MAX_HOLD <= 2) ? 1 : $clog2(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    logic [CW-1:0] hold_q;
    logic          exp_q;

    // Expiry only matters when someone else is waiting; otherwise stay parked.
    assign expire = req_cur && (hold_q == HOLD_LAST) && pick_found;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hold_q <= '0;
            exp_q  <= 1'b0;
        end else begin
            exp_q <= expire;
            if (chg_d) begin
                hold_q <= '0;
            end else if (req_cur && (hold_q != HOLD_LAST)) begin
                hold_q <= hold_q + 1'b1;
            end
        end
    end

    assign hold_expired = exp_q;
`else
    assign expire       = 1'b0;
    assign hold_expired = 1'b0;
`endif

    always_comb begin
        cur_d = cur_q;
        if (!cur_valid) begin
            cur_d = '0;
        end else if ((!req_cur || expire) && pick_found) begin
            cur_d = pick_idx;
        end
        chg_d = (cur_d != cur_q);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cur_q <= IW'(CONBUS_RESET_GNT);
            chg_q <= 1'b0;
        end else begin
            cur_q <= cur_d;
            chg_q <= chg_d;
        end
    end

    // Outputs decode the registered grantee only, so req never reaches gnt combinationally.
    always_comb begin
        gnt = '0;
        if (cur_valid) begin
            gnt[cur_q] = 1'b1;
        end else begin
            gnt[0] = 1'b1;
        end
    end

    assign gnt_idx = cur_q;
    assign gnt_chg = chg_q;

endmodule

// File: tb/tb_conbus_rr_arb.sv
// Scoreboard bench for conbus_rr_arb; honours CONBUS_ARB_TIMEOUT_EN when defined.
module tb_conbus_rr_arb;

    localparam int unsigned N  = 4;
    localparam int unsigned MH = 4;
`ifdef CONBUS_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct packed {
        logic [N-1:0] gnt;
        logic [1:0]   idx;
        logic         chg;
        logic         hexp;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_idx;
    logic         gnt_chg;
    logic         hold_expired;

    int total = 0;
    int bad   = 0;
    int cycle = 0;
    exp_t sb_q[$];

    int m_cur;
    int m_cnt;

    conbus_rr_arb #(
        .N_MASTERS (N),
        .MAX_HOLD  (MH)
    ) dut (
        .sys_clk      (clk),
        .sys_rst_n    (rst_n),
        .req          (req),
        .gnt          (gnt),
        .gnt_idx      (gnt_idx),
        .gnt_chg      (gnt_chg),
        .hold_expired (hold_expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cycle, act, want);
        end
    endtask

    // Reference: holder keeps the bus while requesting (unless its tenure is
    // used up and someone waits); otherwise the bus goes to the nearest
    // requester going round from the holder.
    task automatic model_edge(input logic [N-1:0] r);
        exp_t e;
        int   nxt;
        bit   holder;
        bit   others;
        bit   expire;
        holder = r[m_cur];
        others = 1'b0;
        for (int k = 0; k < N; k++) if (k != m_cur && r[k]) others = 1'b1;
        expire = TO_EN && holder && (m_cnt == MH - 1) && others;
        nxt = m_cur;
        if ((!holder || expire) && others) begin
            for (int k = N - 1; k >= 1; k--)
                if (r[(m_cur + k) % N]) nxt = (m_cur + k) % N;
        end
        e.chg  = (nxt != m_cur);
        e.hexp = expire;
        if (e.chg) m_cnt = 0;
        else if (holder && m_cnt < MH - 1) m_cnt++;
        m_cur = nxt;
        e.gnt = N'(1) << m_cur;
        e.idx = 2'(m_cur);
        sb_q.push_back(e);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic [N-1:0] v);
        req = v;
        model_edge(v);
        @(negedge clk);
    endtask

    task automatic do_reset();
        req   = '1;
        rst_n = 1'b0;
        #1;
        check("rst_gnt",  32'(gnt), 32'b0001);
        check("rst_idx",  32'(gnt_idx), 0);
        check("rst_chg",  32'(gnt_chg), 0);
        check("rst_hexp", 32'(hold_expired), 0);
        m_cur = 0;
        m_cnt = 0;
        @(negedge clk);
        check("rst_hold_gnt", 32'(gnt), 32'b0001);
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("gnt",          32'(gnt), 32'(e.gnt));
                check("gnt_idx",      32'(gnt_idx), 32'(e.idx));
                check("gnt_chg",      32'(gnt_chg), 32'(e.chg));
                check("hold_expired", 32'(hold_expired), 32'(e.hexp));
                check("onehot",       32'($countones(gnt)), 1);
            end
        end
    end

    initial begin : driver
        logic [N-1:0] r;
        rst_n = 1'b0;
        req   = '1;
        @(negedge clk);
        do_reset();

        repeat (3) step(4'b1111);
        step(4'b1010);
        step(4'b1010);
        step(4'b1000);

        step(4'b0111);
        step(4'b1110);
        step(4'b1101);
        step(4'b1011);
        step(4'b0111);

        step(4'b0100);
        repeat (10) step(4'b0000);

        // Reset in the middle of a tenure, then resume from master 0.
        step(4'b0110);
        do_reset();
        repeat (10) step(4'b0011);
        repeat (100) step(4'b0001);

        r = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
            step(r);
        end

        @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(sb_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
